// File: rtl/axis_vlan_classify.sv
// Per-packet classifier and action aligner: pops one VLAN action per frame and
// presents it, with an EtherType-derived packet type, beat-aligned through one AXIS register stage.
module axis_vlan_classify #(
    parameter int DATA_WIDTH    = 512,
    parameter int KEEP_WIDTH    = DATA_WIDTH/8,
    parameter int ID_WIDTH      = 8,
    parameter int DEST_WIDTH    = 4,
    parameter int USER_WIDTH    = 4,
    parameter int VLAN_OP_WIDTH = 2,
    parameter int VLAN_WIDTH    = 16,
    parameter int PT_WIDTH      = 4,
    parameter logic [PT_WIDTH-1:0] PT_IPV4 = 4'h1,
    parameter logic [PT_WIDTH-1:0] PT_VLV4 = 4'h2,
    parameter logic [PT_WIDTH-1:0] PT_IPV6 = 4'h3,
    parameter logic [PT_WIDTH-1:0] PT_VLV6 = 4'h4,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [VLAN_OP_WIDTH-1:0] s_act_vlan_op,
    input  logic [VLAN_WIDTH-1:0]    s_act_vlan_data,
    input  logic                     s_act_valid,
    output logic                     s_act_ready,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic [ID_WIDTH-1:0]      s_axis_tid,
    input  logic [DEST_WIDTH-1:0]    s_axis_tdest,
    input  logic [USER_WIDTH-1:0]    s_axis_tuser,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [ID_WIDTH-1:0]      m_axis_tid,
    output logic [DEST_WIDTH-1:0]    m_axis_tdest,
    output logic [USER_WIDTH-1:0]    m_axis_tuser,
    output logic [VLAN_OP_WIDTH-1:0] m_vlan_op,
    output logic [VLAN_WIDTH-1:0]    m_vlan_data,
    output logic [PT_WIDTH-1:0]      m_pkt_type,
    output logic [CNT_WIDTH-1:0]     stat_pkt_cnt,
    output logic [CNT_WIDTH-1:0]     stat_vlan_cnt
);

    logic                     r_in_frame;
    logic [DATA_WIDTH-1:0]    r_tdata;
    logic [KEEP_WIDTH-1:0]    r_tkeep;
    logic                     r_tvalid;
    logic                     r_tlast;
    logic [ID_WIDTH-1:0]      r_tid;
    logic [DEST_WIDTH-1:0]    r_tdest;
    logic [USER_WIDTH-1:0]    r_tuser;
    logic [VLAN_OP_WIDTH-1:0] r_vlan_op;
    logic [VLAN_WIDTH-1:0]    r_vlan_data;
    logic [PT_WIDTH-1:0]      r_pkt_type;
    logic [CNT_WIDTH-1:0]     r_pkt_cnt;
    logic [CNT_WIDTH-1:0]     r_vlan_cnt;

    logic                     w_ready;
    logic                     w_accept;
    logic                     w_drain;
    logic [15:0]              w_et;
    logic [15:0]              w_inner_et;
    logic [PT_WIDTH-1:0]      w_pkt_type;

    // A first beat may only enter together with its action.
    assign w_ready    = (!r_tvalid || m_axis_tready) && (r_in_frame || s_act_valid);
    assign w_accept   = s_axis_tvalid && w_ready;
    assign w_drain    = r_tvalid && m_axis_tready;
    assign w_et       = s_axis_tdata[111:96];
    assign w_inner_et = s_axis_tdata[143:128];

    // EtherTypes are compared as they sit on the wire, so 0x0800 reads as 16'h0008.
    always_comb begin
        w_pkt_type = '0;
        if (w_et == 16'h0008 && (&s_axis_tkeep[13:12]))
            w_pkt_type = PT_IPV4;
        else if (w_et == 16'hdd86 && (&s_axis_tkeep[13:12]))
            w_pkt_type = PT_IPV6;
        else if (w_et == 16'h0081 && (&s_axis_tkeep[17:16])) begin
            if (w_inner_et == 16'h0008)
                w_pkt_type = PT_VLV4;
            else if (w_inner_et == 16'hdd86)
                w_pkt_type = PT_VLV6;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_frame  <= 1'b0;
            r_tdata     <= '0;
            r_tkeep     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tid       <= '0;
            r_tdest     <= '0;
            r_tuser     <= '0;
            r_vlan_op   <= '0;
            r_vlan_data <= '0;
            r_pkt_type  <= '0;
            r_pkt_cnt   <= '0;
            r_vlan_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_in_frame <= !s_axis_tlast;
                r_tdata    <= s_axis_tdata;
                r_tkeep    <= s_axis_tkeep;
                r_tvalid   <= 1'b1;
                r_tlast    <= s_axis_tlast;
                r_tid      <= s_axis_tid;
                r_tdest    <= s_axis_tdest;
                r_tuser    <= s_axis_tuser;
                if (!r_in_frame) begin
                    r_vlan_op   <= s_act_vlan_op;
                    r_vlan_data <= s_act_vlan_data;
                    r_pkt_type  <= w_pkt_type;
                end else begin
                    r_vlan_op   <= '0;
                end
            end else if (m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
            // Counters see the type latched with the outgoing frame, not the incoming one.
            if (w_drain && r_tlast) begin
                r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
                if (r_pkt_type == PT_VLV4 || r_pkt_type == PT_VLV6)
                    r_vlan_cnt <= r_vlan_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign s_axis_tready = w_ready;
    assign s_act_ready   = w_accept && !r_in_frame;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tid    = r_tid;
    assign m_axis_tdest  = r_tdest;
    assign m_axis_tuser  = r_tuser;
    assign m_vlan_op     = r_vlan_op;
    assign m_vlan_data   = r_vlan_data;
    assign m_pkt_type    = r_pkt_type;
    assign stat_pkt_cnt  = r_pkt_cnt;
    assign stat_vlan_cnt = r_vlan_cnt;

endmodule

// File: tb/tb_axis_vlan_classify.sv
// Directed bench for axis_vlan_classify: classification, action alignment,
// action gating, backpressure, counters and mid-frame reset.
module tb_axis_vlan_classify;

    localparam int DW = 512;
    localparam int KW = DW/8;
    localparam logic [KW-1:0] KALL = '1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    s_act_vlan_op = '0;
    logic [15:0]   s_act_vlan_data = '0;
    logic          s_act_valid = 1'b0;
    logic          s_act_ready;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [7:0]    s_axis_tid = '0;
    logic [3:0]    s_axis_tdest = '0;
    logic [3:0]    s_axis_tuser = '0;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic [7:0]    m_axis_tid;
    logic [3:0]    m_axis_tdest;
    logic [3:0]    m_axis_tuser;
    logic [1:0]    m_vlan_op;
    logic [15:0]   m_vlan_data;
    logic [3:0]    m_pkt_type;
    logic [31:0]   stat_pkt_cnt;
    logic [31:0]   stat_vlan_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int pops    = 0;
    logic [31:0] mq[$];

    axis_vlan_classify dut (
        .clk(clk), .rst(rst),
        .s_act_vlan_op(s_act_vlan_op), .s_act_vlan_data(s_act_vlan_data),
        .s_act_valid(s_act_valid), .s_act_ready(s_act_ready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
        .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
        .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
        .m_vlan_op(m_vlan_op), .m_vlan_data(m_vlan_data), .m_pkt_type(m_pkt_type),
        .stat_pkt_cnt(stat_pkt_cnt), .stat_vlan_cnt(stat_vlan_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && s_act_valid && s_act_ready) pops++;
        if (!rst && m_axis_tvalid && m_axis_tready) mq.push_back(m_axis_tdata[31:0]);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [31:0] tag, input logic [15:0] et,
                                         input logic [15:0] inner);
        logic [DW-1:0] d;
        d = '0;
        d[31:0]    = tag;
        d[111:96]  = et;
        d[143:128] = inner;
        return d;
    endfunction

    // Present one beat (and optionally an action), wait for acceptance, then withdraw.
    task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic last,
                        input logic av, input logic [1:0] op, input logic [15:0] vd);
        bit ok;
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = last; s_axis_tvalid = 1'b1;
        s_act_valid = av; s_act_vlan_op = op; s_act_vlan_data = vd;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (s_axis_tready) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0; s_act_valid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] t, input logic [1:0] op,
                           input logic [15:0] vd, input logic [3:0] pt);
        chk({tag, "_valid"}, m_axis_tvalid, 1'b1);
        chk({tag, "_data"},  m_axis_tdata[31:0], t);
        chk({tag, "_op"},    m_vlan_op, op);
        chk({tag, "_vdata"}, m_vlan_data, vd);
        chk({tag, "_type"},  m_pkt_type, pt);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        // reset state
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_type", m_pkt_type, 0);
        chk("rst_pkt_cnt", stat_pkt_cnt, 0);
        chk("rst_vlan_cnt", stat_vlan_cnt, 0);
        chk("rst_s_tready", s_axis_tready, 0);

        // IPv4 single beat
        s_axis_tid = 8'h5a;
        send(mk(32'h11, 16'h0008, 16'h0), KALL, 1, 1, 2'b01, 16'h0064);
        chk_out("ipv4", 32'h11, 2'b01, 16'h0064, 4'h1);
        chk("ipv4_last", m_axis_tlast, 1);
        chk("ipv4_tid", m_axis_tid, 8'h5a);
        @(posedge clk); #1;
        chk("ipv4_pkt_cnt", stat_pkt_cnt, 1);
        chk("ipv4_drained", m_axis_tvalid, 0);
        chk("ipv4_pops", pops, 1);

        // VLAN+IPv6, 3 beats
        send(mk(32'h20, 16'h0081, 16'hdd86), KALL, 0, 1, 2'b11, 16'h2005);
        chk_out("vlv6_b0", 32'h20, 2'b11, 16'h2005, 4'h4);
        send(mk(32'h21, 16'h0, 16'h0), KALL, 0, 0, 2'b00, 16'h0);
        chk_out("vlv6_b1", 32'h21, 2'b00, 16'h2005, 4'h4);
        send(mk(32'h22, 16'h0, 16'h0), KALL, 1, 0, 2'b00, 16'h0);
        chk_out("vlv6_b2", 32'h22, 2'b00, 16'h2005, 4'h4);
        @(posedge clk); #1;
        chk("vlv6_pkt_cnt", stat_pkt_cnt, 2);
        chk("vlv6_vlan_cnt", stat_vlan_cnt, 1);

        // No action: frame stalls until the action arrives
        s_axis_tdata = mk(32'h30, 16'hdd86, 16'h0); s_axis_tkeep = KALL;
        s_axis_tlast = 1; s_axis_tvalid = 1; s_act_valid = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("noact_s_tready", s_axis_tready, 0);
            chk("noact_m_tvalid", m_axis_tvalid, 0);
        end
        @(posedge clk); #1;
        send(mk(32'h30, 16'hdd86, 16'h0), KALL, 1, 1, 2'b00, 16'h0007);
        chk_out("ipv6", 32'h30, 2'b00, 16'h0007, 4'h3);
        @(posedge clk); #1;
        chk("ipv6_pkt_cnt", stat_pkt_cnt, 3);

        // Backpressure mid-frame on a VLAN+IPv4 frame
        mq.delete();
        send(mk(32'h40, 16'h0081, 16'h0008), KALL, 0, 1, 2'b01, 16'h0abc);
        m_axis_tready = 0;
        s_axis_tdata = mk(32'h41, 16'h0, 16'h0); s_axis_tlast = 0; s_axis_tvalid = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_s_tready", s_axis_tready, 0);
            chk("bp_hold_tag", m_axis_tdata[31:0], 32'h40);
            chk("bp_hold_op", m_vlan_op, 2'b01);
        end
        @(posedge clk); #1;
        m_axis_tready = 1;
        send(mk(32'h41, 16'h0, 16'h0), KALL, 0, 0, 2'b00, 16'h0);
        chk_out("bp_b1", 32'h41, 2'b00, 16'h0abc, 4'h2);
        send(mk(32'h42, 16'h0, 16'h0), KALL, 1, 0, 2'b00, 16'h0);
        @(posedge clk); #1;
        chk("bp_beats", mq.size(), 3);
        if (mq.size() == 3) begin
            chk("bp_q0", mq[0], 32'h40);
            chk("bp_q1", mq[1], 32'h41);
            chk("bp_q2", mq[2], 32'h42);
        end
        chk("bp_vlan_cnt", stat_vlan_cnt, 2);

        // ARP and short tkeep both classify as default
        send(mk(32'h50, 16'h0608, 16'h0), KALL, 1, 1, 2'b10, 16'h0123);
        chk_out("arp", 32'h50, 2'b10, 16'h0123, 4'h0);
        send(mk(32'h51, 16'h0008, 16'h0), KW'(64'h0fff), 1, 1, 2'b01, 16'h0055);
        chk_out("short", 32'h51, 2'b01, 16'h0055, 4'h0);
        @(posedge clk); #1;
        chk("arp_pkt_cnt", stat_pkt_cnt, 6);
        chk("arp_vlan_cnt", stat_vlan_cnt, 2);
        chk("pops_before_rst", pops, 6);

        // Reset during beat 2 of a 4-beat frame
        send(mk(32'h60, 16'h0008, 16'h0), KALL, 0, 1, 2'b01, 16'h0011);
        send(mk(32'h61, 16'h0, 16'h0), KALL, 0, 0, 2'b00, 16'h0);
        s_axis_tdata = mk(32'h62, 16'h0, 16'h0); s_axis_tlast = 0; s_axis_tvalid = 1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; s_axis_tvalid = 0;
        chk("mrst_tvalid", m_axis_tvalid, 0);
        chk("mrst_tdata", m_axis_tdata[31:0], 0);
        chk("mrst_op", m_vlan_op, 0);
        chk("mrst_vdata", m_vlan_data, 0);
        chk("mrst_type", m_pkt_type, 0);
        chk("mrst_pkt_cnt", stat_pkt_cnt, 0);
        send(mk(32'h63, 16'h0, 16'h0), KALL, 1, 1, 2'b11, 16'h0abc);
        chk_out("mrst_b3", 32'h63, 2'b11, 16'h0abc, 4'h0);
        @(posedge clk); #1;
        chk("mrst_pkt_cnt2", stat_pkt_cnt, 1);
        chk("mrst_vlan_cnt2", stat_vlan_cnt, 0);
        chk("total_pops", pops, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
